// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: opcode, funct3 and funct7 constants plus the
// decoded issue-entry layout and FIFO occupancy states.
package alu_issue_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} fifo_state_t;

  typedef struct packed {
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  op;
    logic        mod;
    logic        operand_2_neg;
    logic        rd_we;
    logic        illegal;
  } issue_entry_t;

  // Only ADD/SUB and SRL/SRA accept the alternate funct7 encoding.
  function automatic logic is_alt_funct3(input logic [2:0] f3);
    return (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_stage_ctrl_decode.sv
// Combinational decode of one fetched instruction into an issue entry.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0]  instr,
  output issue_entry_t entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    entry         = '0;
    legal         = 1'b0;
    entry.rd_idx  = instr[11:7];
    entry.rs1_idx = instr[19:15];
    entry.rs2_idx = instr[24:20];
    case (opcode)
      OPC_OP: begin
        legal               = (funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && is_alt_funct3(funct3));
        entry.op            = funct3;
        entry.operand_2_neg = (funct3 == F3_ADD_SUB) && instr[30];
        entry.mod           = (funct3 == F3_SRL_SRA) && instr[30];
      end
      OPC_OP_IMM: begin
        entry.use_imm = 1'b1;
        entry.rs2_idx = '0;
        entry.op      = funct3;
        if (funct3 == F3_SLL) begin
          legal     = (funct7 == F7_BASE);
          entry.imm = {27'd0, instr[24:20]};
        end else if (funct3 == F3_SRL_SRA) begin
          legal     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          entry.imm = {27'd0, instr[24:20]};
          entry.mod = instr[30];
        end else begin
          legal     = 1'b1;
          entry.imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI: begin
        legal         = 1'b1;
        entry.use_imm = 1'b1;
        entry.rs1_idx = '0;
        entry.rs2_idx = '0;
        entry.imm     = {instr[31:12], 12'd0};
      end
      default: legal = 1'b0;
    endcase

    // Illegal entries still issue, but with every ALU control neutralised.
    if (!legal) begin
      entry.op            = F3_ADD_SUB;
      entry.mod           = 1'b0;
      entry.operand_2_neg = 1'b0;
      entry.use_imm       = 1'b0;
      entry.imm           = '0;
      entry.rd_we         = 1'b0;
    end else begin
      entry.rd_we = (entry.rd_idx != 5'd0);
    end
    entry.illegal = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes fetched instructions and buffers them in a
// 2-entry registered FIFO toward the ALU operand-fetch stage.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [4:0]  rd_idx,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic [2:0]  op,
  output logic        mod,
  output logic        operand_2_neg,
  output logic        rd_we,
  output logic        illegal
);

  fifo_state_t  state;
  issue_entry_t dec_entry;
  issue_entry_t head;
  issue_entry_t tail;
  logic         push;
  logic         pop;

  alu_ctrl_decode u_decode (
    .instr (instr),
    .entry (dec_entry)
  );

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (state != EMPTY);

  // Occupancy FSM; head always holds the oldest entry, tail the younger one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (push) begin
            state <= ONE;
            head  <= dec_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= dec_entry;
          end else if (push) begin
            state    <= TWO;
            tail     <= dec_entry;
            in_ready <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state <= ONE;
            head  <= tail;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign rs1_idx       = head.rs1_idx;
  assign rs2_idx       = head.rs2_idx;
  assign rd_idx        = head.rd_idx;
  assign imm           = head.imm;
  assign use_imm       = head.use_imm;
  assign op            = head.op;
  assign mod           = head.mod;
  assign operand_2_neg = head.operand_2_neg;
  assign rd_we         = head.rd_we;
  assign illegal       = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed decode cases, stall, flush,
// reset, then randomized traffic checked against a behavioural decoder.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, imm;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [2:0]  op;
  logic        use_imm, mod, operand_2_neg, rd_we, illegal;

  int           tests = 0;
  int           fails = 0;
  issue_entry_t expq[$];
  bit           rst_seen = 1'b1;
  bit           check_en = 1'b0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
    .imm(imm), .use_imm(use_imm), .op(op), .mod(mod),
    .operand_2_neg(operand_2_neg), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decoder written from the instruction-class rules.
  function automatic issue_entry_t refDecode(input logic [31:0] i);
    issue_entry_t e;
    logic [6:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    bit           ok;
    e   = '0;
    opc = i[6:0];
    f3  = i[14:12];
    f7  = i[31:25];
    ok  = 1'b0;
    e.rd_idx = i[11:7];
    if (opc == 7'b0110011) begin
      ok = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.rs1_idx       = i[19:15];
      e.rs2_idx       = i[24:20];
      e.op            = f3;
      e.operand_2_neg = (f3 == 3'd0) && (f7 == 7'h20);
      e.mod           = (f3 == 3'd5) && (f7 == 7'h20);
    end else if (opc == 7'b0010011) begin
      if (f3 == 3'd1)      ok = (f7 == 7'd0);
      else if (f3 == 3'd5) ok = (f7 == 7'd0) || (f7 == 7'h20);
      else                 ok = 1'b1;
      e.rs1_idx = i[19:15];
      e.use_imm = 1'b1;
      e.op      = f3;
      e.mod     = (f3 == 3'd5) && (f7 == 7'h20);
      if (f3 == 3'd1 || f3 == 3'd5) e.imm = {27'd0, i[24:20]};
      else                          e.imm = {{20{i[31]}}, i[31:20]};
    end else if (opc == 7'b0110111) begin
      ok        = 1'b1;
      e.use_imm = 1'b1;
      e.imm     = i & 32'hFFFF_F000;
    end
    if (!ok) begin
      e = '0;
      e.illegal = 1'b1;
    end else begin
      e.rd_we = (e.rd_idx != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       f7 = 7'd0;
      1:       f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 5))
      0, 1:    return {f7, r[24:7], 7'b0110011};
      2, 3:    return {f7, r[24:7], 7'b0010011};
      4:       return {r[31:7], 7'b0110111};
      default: return r;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic checkHead(input string name, input bit chk_idx,
                           input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                           input logic [31:0] e_rd, input logic [31:0] e_imm,
                           input logic [31:0] e_use, input logic [31:0] e_op,
                           input logic [31:0] e_mod, input logic [31:0] e_neg,
                           input logic [31:0] e_we, input logic [31:0] e_ill);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    if (chk_idx) begin
      checkOutput({name, "_rs1"}, 32'(rs1_idx), e_rs1);
      checkOutput({name, "_rs2"}, 32'(rs2_idx), e_rs2);
      checkOutput({name, "_rd"},  32'(rd_idx),  e_rd);
    end
    checkOutput({name, "_imm"},     imm,                  e_imm);
    checkOutput({name, "_use_imm"}, 32'(use_imm),         e_use);
    checkOutput({name, "_op"},      32'(op),              e_op);
    checkOutput({name, "_mod"},     32'(mod),             e_mod);
    checkOutput({name, "_neg"},     32'(operand_2_neg),   e_neg);
    checkOutput({name, "_rd_we"},   32'(rd_we),           e_we);
    checkOutput({name, "_illegal"}, 32'(illegal),         e_ill);
  endtask

  // Holds in_valid until the instruction is accepted, bounded to 20 cycles.
  task automatic applyStimulus(input logic [31:0] i);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    instr    = i;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Scoreboard input side: record accepted instructions, clear on flush/reset.
  always @(posedge clk) begin
    if (!rst_n || flush) expq.delete();
    else if (in_valid && in_ready) expq.push_back(refDecode(instr));
    rst_seen = !rst_n;
  end

  // Monitor: compare the presented head with the oldest expected entry.
  always @(negedge clk) begin
    if (check_en) begin
      issue_entry_t act, exp;
      checkOutput("mon_out_valid", 32'(out_valid), 32'(expq.size() != 0));
      checkOutput("mon_in_ready", 32'(in_ready), 32'(!rst_seen && expq.size() < 2));
      if (out_valid && expq.size() != 0) begin
        exp = expq[0];
        act = '{rs1_idx, rs2_idx, rd_idx, imm, use_imm, op, mod,
                operand_2_neg, rd_we, illegal};
        if (exp.illegal) begin
          act.rs1_idx = '0; act.rs2_idx = '0; act.rd_idx = '0;
        end
        tests++;
        if (act !== exp) begin
          fails++;
          $display("[TB] FAIL head_entry: got 0x%h, expected 0x%h", act, exp);
        end
        if (out_ready && rst_n && !flush) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd0);
    checkOutput("reset_imm",       imm,            32'd0);
    checkOutput("reset_rd_we",     32'(rd_we),     32'd0);
    checkOutput("reset_illegal",   32'(illegal),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Directed decode cases, each observed one cycle after acceptance.
    applyStimulus(32'h002081B3); @(negedge clk);
    checkHead("add", 1, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0); popOne();
    applyStimulus(32'h402081B3); @(negedge clk);
    checkHead("sub", 1, 1, 2, 3, 0, 0, 0, 0, 1, 1, 0); popOne();
    applyStimulus(32'h40335293); @(negedge clk);
    checkHead("srai", 1, 6, 0, 5, 3, 1, 5, 1, 0, 1, 0); popOne();
    applyStimulus(32'hFFF00093); @(negedge clk);
    checkHead("addi", 1, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0); popOne();
    applyStimulus(32'h123453B7); @(negedge clk);
    checkHead("lui", 1, 0, 0, 7, 32'h12345000, 1, 0, 0, 0, 1, 0); popOne();
    applyStimulus(32'h022081B3); @(negedge clk);
    checkHead("bad_f7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); popOne();
    applyStimulus(32'h00000073); @(negedge clk);
    checkHead("bad_opc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); popOne();

    // Back-pressure: third instruction must wait while the FIFO is full.
    applyStimulus(32'h002081B3);
    applyStimulus(32'h40335293);
    in_valid = 1'b1;
    instr    = 32'h123453B7;
    repeat (3) begin
      @(negedge clk);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_head_rd", 32'(rd_idx), 32'd3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(32'h123453B7);
    drain();
    out_ready = 1'b0;

    // Flush with a full FIFO and a same-cycle push.
    applyStimulus(32'h002081B3);
    applyStimulus(32'h402081B3);
    in_valid = 1'b1; instr = 32'hFFF00093; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_in_ready",  32'(in_ready),  32'd1);
    end

    // Reset mid-stream.
    @(posedge clk);
    #1;
    applyStimulus(32'h002081B3);
    applyStimulus(32'h402081B3);
    in_valid = 1'b1; instr = 32'hFFF00093; rst_n = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_mid_rd",        32'(rd_idx),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      instr     = randInstr();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    drain();

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), instr (input, 32): fetched-instruction handshake.
REQ-005 SHALL have ports out_valid (output, 1), out_ready (input, 1): issue handshake toward the ALU operand-fetch stage.
REQ-006 SHALL have outputs rs1_idx, rs2_idx, rd_idx (5 each): register indices.
REQ-007 SHALL have outputs imm (32), use_imm (1): immediate and operand-2 select.
REQ-008 SHALL have outputs op (3), mod (1), operand_2_neg (1): ALU controls, op = funct3 encoding.
REQ-009 SHALL have outputs rd_we (1), illegal (1): writeback enable and illegal-instruction flag.

Function
REQ-010 SHALL decode OP (0110011), OP-IMM (0010011), LUI (0110111); all other opcodes illegal.
REQ-011 SHALL set op = instr[14:12] for OP/OP-IMM; op = 000 for LUI.
REQ-012 SHALL set operand_2_neg = instr[30] only for OP with funct3 000 (SUB); 0 otherwise, including ADDI.
REQ-013 SHALL set mod = instr[30] only for funct3 101 (SRL/SRA, SRLI/SRAI); 0 otherwise.
REQ-014 SHALL set imm: OP-IMM shifts = zero-extended instr[24:20]; other OP-IMM = sign-extended instr[31:20]; LUI = {instr[31:12], 12'b0}; OP = 0.
REQ-015 SHALL set use_imm = 1 for OP-IMM and LUI; rs1_idx = 0 for LUI; rs2_idx = 0 when use_imm.
REQ-016 SHALL flag illegal for OP funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}.
REQ-017 SHALL flag illegal for SLLI funct7 != 0 and SRLI/SRAI funct7 not in {0000000, 0100000}.
REQ-018 An illegal entry SHALL still issue with illegal=1, rd_we=0, op=000, mod=0, operand_2_neg=0, use_imm=0, imm=0.
REQ-019 Legal entries SHALL issue with rd_we = (rd_idx != 0).
REQ-020 SHALL register decoded fields in a 2-entry FIFO; occupancy states EMPTY, ONE, TWO.
REQ-021 Transfer SHALL occur when valid and ready are both high in the same cycle, on either side.
REQ-022 in_ready SHALL be a registered output equal to (state != TWO).
REQ-023 out_valid SHALL equal (state != EMPTY); outputs SHALL present the head entry.
REQ-024 Transitions: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop; simultaneous push and pop leaves state unchanged.
REQ-025 Latency SHALL be 1 cycle from accepted instr to out_valid when EMPTY; sustained throughput 1 per cycle.
REQ-026 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 flush SHALL force EMPTY next cycle, dropping any same-cycle push; flush overrides push and pop.

Reset
REQ-028 While rst_n=0 at a clock edge: state=EMPTY, out_valid=0, in_ready=0; all entry fields cleared to 0.
REQ-029 in_ready SHALL rise on the first edge after rst_n returns to 1; reset mid-transfer discards all entries.

Structure
REQ-030 Opcode constants, funct3 ALU op codes and funct7 constants SHALL live in the shared ALU definitions package used by the ALU.
REQ-031 Combinational decode SHALL be one sub-module, alu_ctrl_decode, instantiated once at the FIFO input.
REQ-032 FIFO and state machine SHALL be in alu_issue_stage; no combinational in->out path.

Verification
REQ-033 Push 0x002081B3 (ADD x3,x1,x2) -> next cycle rs1=1, rs2=2, rd=3, op=000, operand_2_neg=0, use_imm=0, rd_we=1.
REQ-034 Push 0x402081B3 (SUB) -> operand_2_neg=1, op=000; push 0x40335293 (SRAI x5,x6,3) -> imm=3, mod=1, op=101, use_imm=1.
REQ-035 Push 0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF; push 0x123453B7 (LUI x7) -> imm=0x12345000, rs1=0, use_imm=1.
REQ-036 Push 0x022081B3 (funct7 0000001) -> illegal=1, rd_we=0; push 0x00000073 -> illegal=1.
REQ-037 Hold out_ready=0, push 3 instrs -> in_ready=0 after 2 accepted, 3rd held; release -> order preserved, outputs stable while stalled.
REQ-038 Assert flush with state TWO and in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry issued; rst_n=0 mid-stream -> same.
